branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 97 +++++++++
 tb/tb_branch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// LC-3 style BR evaluator: latches IR/NZP/PC on Start, then EVAL -> ADD -> WRITE,
// producing BEN, the branch target, a PC-load strobe and a taken-branch counter.
module branch_unit #(
   parameter int CNT_W = 16
) (
   input  logic             i_CLK,
   input  logic             i_RST_n,
   input  logic             i_Start,
   input  logic             i_LD_BEN,
   input  logic [15:0]      i_IR,
   input  logic [2:0]       i_NZP,
   input  logic [15:0]      i_PC,
   input  logic             i_Clr_Cnt,
   output logic             o_BEN,
   output logic [15:0]      o_Target,
   output logic             o_LD_PC,
   output logic             o_Busy,
   output logic             o_Done,
   output logic [CNT_W-1:0] o_Taken_Cnt,
   output logic [1:0]       o_State
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVAL  = 2'd1,
      ADD   = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] ir_q;
   logic [15:0] pc_q;
   logic [2:0]  nzp_q;
   logic [15:0] offset_sext;

   assign offset_sext = {{7{ir_q[8]}}, ir_q[8:0]};
   assign o_State     = state;

   // Handshake: i_Start is a one-cycle request taken only in IDLE (o_Busy=0);
   // completion is the single-cycle o_Done in WRITE, with o_LD_PC = o_BEN alongside.
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state    <= IDLE;
         ir_q     <= 16'h0000;
         pc_q     <= 16'h0000;
         nzp_q    <= 3'b000;
         o_BEN    <= 1'b0;
         o_Target <= 16'h0000;
         o_LD_PC  <= 1'b0;
         o_Done   <= 1'b0;
         o_Busy   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_Start) begin
                  ir_q   <= i_IR;
                  nzp_q  <= i_NZP;
                  pc_q   <= i_PC;
                  o_Busy <= 1'b1;
                  state  <= EVAL;
               end else if (i_LD_BEN) begin
                  o_BEN <= |(i_IR[11:9] & i_NZP);
               end
            end
            EVAL: begin
               o_BEN <= |(ir_q[11:9] & nzp_q);
               state <= ADD;
            end
            ADD: begin
               // Strobes are registered on entry to WRITE so they are high only there.
               o_Target <= pc_q + offset_sext;
               o_LD_PC  <= o_BEN;
               o_Done   <= 1'b1;
               state    <= WRITE;
            end
            WRITE: begin
               o_LD_PC <= 1'b0;
               o_Done  <= 1'b0;
               o_Busy  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         o_Taken_Cnt <= '0;
      end else if (i_Clr_Cnt) begin
         o_Taken_Cnt <= '0;
      end else if (state == WRITE && o_BEN && o_Taken_Cnt != '1) begin
         o_Taken_Cnt <= o_Taken_Cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed BR cases, random branches,
// counter saturation/clear, LD_BEN behaviour and mid-sequence reset.
module tb_branch_unit;

   localparam int CNT_W = 4;

   logic             i_CLK;
   logic             i_RST_n;
   logic             i_Start;
   logic             i_LD_BEN;
   logic [15:0]      i_IR;
   logic [2:0]       i_NZP;
   logic [15:0]      i_PC;
   logic             i_Clr_Cnt;
   logic             o_BEN;
   logic [15:0]      o_Target;
   logic             o_LD_PC;
   logic             o_Busy;
   logic             o_Done;
   logic [CNT_W-1:0] o_Taken_Cnt;
   logic [1:0]       o_State;

   int               total = 0;
   int               bad   = 0;
   logic [16:0]      exp_q[$];
   logic [16:0]      mon_e;
   logic [CNT_W-1:0] cnt_model;
   logic [15:0]      t_keep;

   branch_unit #(.CNT_W(CNT_W)) dut (
      .i_CLK       (i_CLK),
      .i_RST_n     (i_RST_n),
      .i_Start     (i_Start),
      .i_LD_BEN    (i_LD_BEN),
      .i_IR        (i_IR),
      .i_NZP       (i_NZP),
      .i_PC        (i_PC),
      .i_Clr_Cnt   (i_Clr_Cnt),
      .o_BEN       (o_BEN),
      .o_Target    (o_Target),
      .o_LD_PC     (o_LD_PC),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done),
      .o_Taken_Cnt (o_Taken_Cnt),
      .o_State     (o_State)
   );

   // clock / watchdog
   initial i_CLK = 1'b0;
   always #5 i_CLK = ~i_CLK;

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: each o_Done pops one {ben, target} expectation
   always @(negedge i_CLK) begin
      if (o_Done) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", o_Done, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("ben",    o_BEN,    mon_e[16]);
            check_eq("ld_pc",  o_LD_PC,  mon_e[16]);
            check_eq("target", o_Target, mon_e[15:0]);
         end
      end else if (o_LD_PC !== 1'b0) begin
         check_eq("ld_pc_no_done", o_LD_PC, 1'b0);
      end
   end

   // Called at a negedge with the DUT in IDLE; returns at the negedge after WRITE.
   // mode 1: re-Start with new inputs in EVAL; mode 2: LD_BEN during ADD;
   // mode 3: LD_BEN together with Start.
   task automatic run_br(input logic [15:0] ir, input logic [2:0] nzp, input logic [15:0] pc,
                         input int mode, input bit clr);
      logic ben;
      int   lat;
      int   busy_n;
      ben = |(ir[11:9] & nzp);
      exp_q.push_back({ben, 16'(pc + {{7{ir[8]}}, ir[8:0]})});
      i_IR     = ir;
      i_NZP    = nzp;
      i_PC     = pc;
      i_Start  = 1'b1;
      i_LD_BEN = (mode == 3);
      @(negedge i_CLK);
      i_Start  = 1'b0;
      i_LD_BEN = 1'b0;
      lat      = 1;
      busy_n   = 0;
      if (mode == 1) begin
         i_IR    = 16'($urandom);
         i_NZP   = 3'($urandom_range(7, 0));
         i_PC    = 16'($urandom);
         i_Start = 1'b1;
      end
      while (!o_Done && lat < 8) begin
         if (o_Busy) busy_n++;
         @(negedge i_CLK);
         lat++;
         i_Start = 1'b0;
         if (mode == 2 && lat == 2) begin
            i_IR     = 16'h0E00;
            i_NZP    = 3'b111;
            i_LD_BEN = 1'b1;
         end else begin
            i_LD_BEN = 1'b0;
         end
      end
      check_eq("latency", lat, 3);
      if (o_Busy) busy_n++;
      if (clr) i_Clr_Cnt = 1'b1;
      @(negedge i_CLK);
      i_Clr_Cnt = 1'b0;
      if (clr) cnt_model = '0;
      else if (ben && cnt_model != '1) cnt_model++;
      check_eq("busy_cycles", busy_n, 3);
      check_eq("busy_idle", o_Busy, 1'b0);
      check_eq("taken_cnt", o_Taken_Cnt, cnt_model);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ben"},    o_BEN,       1'b0);
      check_eq({tag, "_target"}, o_Target,    16'h0000);
      check_eq({tag, "_ld_pc"},  o_LD_PC,     1'b0);
      check_eq({tag, "_done"},   o_Done,      1'b0);
      check_eq({tag, "_busy"},   o_Busy,      1'b0);
      check_eq({tag, "_cnt"},    o_Taken_Cnt, '0);
      check_eq({tag, "_state"},  o_State,     2'd0);
   endtask

   initial begin
      i_RST_n   = 1'b1;
      i_Start   = 1'b0;
      i_LD_BEN  = 1'b0;
      i_IR      = 16'h0000;
      i_NZP     = 3'b000;
      i_PC      = 16'h0000;
      i_Clr_Cnt = 1'b0;
      cnt_model = '0;
      #1 i_RST_n = 1'b0;
      #1 check_all_zero("reset");
      @(negedge i_CLK);
      @(negedge i_CLK);
      i_RST_n = 1'b1;

      // directed cases
      run_br(16'h0A05, 3'b100, 16'h3000, 0, 1'b0);
      check_eq("d1_target", o_Target, 16'h3005);
      check_eq("d1_cnt", o_Taken_Cnt, 4'd1);
      run_br(16'h05FF, 3'b001, 16'h3000, 0, 1'b0);
      check_eq("d2_target", o_Target, 16'h2FFF);
      check_eq("d2_ben", o_BEN, 1'b0);
      run_br(16'h0EFF, 3'b010, 16'hFFF0, 0, 1'b0);
      check_eq("d3_target_wrap", o_Target, 16'h00EF);
      run_br(16'h0A05, 3'b100, 16'h1000, 1, 1'b0);
      check_eq("d4_first_latched", o_Target, 16'h1005);
      run_br(16'h0200, 3'b100, 16'h2000, 2, 1'b0);
      check_eq("d5_ldben_busy_ign", o_BEN, 1'b0);
      run_br(16'h0402, 3'b010, 16'h0010, 3, 1'b0);
      check_eq("d6_start_ldben", o_Target, 16'h0012);

      // LD_BEN in IDLE
      t_keep   = o_Target;
      i_IR     = 16'h0E00;
      i_NZP    = 3'b010;
      i_LD_BEN = 1'b1;
      @(negedge i_CLK);
      i_LD_BEN = 1'b0;
      check_eq("ldben_set", o_BEN, 1'b1);
      check_eq("ldben_target_hold", o_Target, t_keep);
      check_eq("ldben_state", o_State, 2'd0);
      i_IR     = 16'h01FF;
      i_NZP    = 3'b111;
      i_LD_BEN = 1'b1;
      @(negedge i_CLK);
      i_LD_BEN = 1'b0;
      check_eq("ldben_mask0", o_BEN, 1'b0);

      // random branches
      for (int i = 0; i < 12; i++)
         run_br(16'($urandom), 3'($urandom_range(7, 0)), 16'($urandom), 0, 1'b0);

      // saturation with forced-taken branches
      for (int i = 0; i < 16; i++)
         run_br({4'($urandom), 3'b111, 9'($urandom)}, 3'($urandom_range(7, 1)),
                16'($urandom), 0, 1'b0);
      check_eq("cnt_sat", o_Taken_Cnt, 4'hF);
      run_br(16'h0E01, 3'b100, 16'h0100, 0, 1'b1);
      check_eq("cnt_clr_prio", o_Taken_Cnt, 4'h0);
      run_br(16'h0E01, 3'b100, 16'h0100, 0, 1'b0);

      // reset during ADD
      i_IR    = 16'h0E10;
      i_NZP   = 3'b001;
      i_PC    = 16'h4000;
      i_Start = 1'b1;
      @(negedge i_CLK);
      i_Start = 1'b0;
      @(negedge i_CLK);
      #2 i_RST_n = 1'b0;
      #1 check_all_zero("midrst");
      cnt_model = '0;
      repeat (3) @(negedge i_CLK);
      i_RST_n = 1'b1;
      run_br(16'h0E10, 3'b001, 16'h4000, 0, 1'b0);
      check_eq("post_rst_target", o_Target, 16'h4010);

      check_eq("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
